axi_lite_regfile: RTL

//  Parametrised AXI4-Lite slave register file; next-generation replacement for the fixed axi_lite slave.

---
 rtl/axi_lite_regfile.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
//   Parametrised AXI4-Lite slave register file. AW and W are accepted
//   independently, out-of-range indices answer DECERR without side effects,
//   and every register is exposed on a flat bus for fabric logic.
//
// Parameters
//   DATA_WIDTH  bus / register width (32 or 64)
//   ADDR_WIDTH  byte address width
//   NUM_REGS    number of registers
//   NUM_RO      number of read-only registers at the top of the map
//               (used only when AXIL_RO_REGS_EN is defined)
//
// Ports
//   ACLKn, ARESETn      clock (rising edge), synchronous active-low reset
//   AW*/W*/B*           write address, write data, write response channels
//   AR*/R*              read address and read data channels
//   reg_out             register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ro_in               read-only register values (AXIL_RO_REGS_EN only)
//
// Build option
//   AXIL_RO_REGS_EN: registers NUM_REGS-NUM_RO..NUM_REGS-1 return ro_in,
//   refuse writes with SLVERR and mirror ro_in on reg_out.
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RO     = 4
) (
  input  logic                           ACLKn,
  input  logic                           ARESETn,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
`ifdef AXIL_RO_REGS_EN
  ,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   ro_in
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
`ifdef AXIL_RO_REGS_EN
  localparam int RO_BASE = NUM_REGS - NUM_RO;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0] cur_val [NUM_REGS];

  // Held halves of a split write transaction.
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  // Effective write operands on the commit edge.
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [1:0]            wr_resp;
  logic                  wr_commit;

  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [1:0]            rd_resp;
  logic                  ar_hs;

  // Byte-offset address bits carry no meaning for word-wide registers.
  logic unused_bits;
  assign unused_bits = ^{AWADDR[OFFS-1:0], ARADDR[OFFS-1:0], NUM_RO[0]};

  // Visible value of each register: storage, or ro_in for read-only slots.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
`ifdef AXIL_RO_REGS_EN
    if (g >= RO_BASE) begin : g_ro
      assign cur_val[g] = ro_in[(g-RO_BASE)*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      assign cur_val[g] = regs[g];
    end
`else
    assign cur_val[g] = regs[g];
`endif
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = cur_val[g];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // not listed in the sensitivity list.
  always_ff @(posedge ACLKn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: next state and channel outputs
  // ---------------------------------------------------------------------------
  // Readies are gated with ARESETn so they read 0 while reset is held, even
  // before the first reset edge has settled the state register.
  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a value unassigned (which would infer a latch).
  always_comb begin
    wr_next   = wr_state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    wr_commit = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        AWREADY = ARESETn;
        WREADY  = ARESETn;
        if (AWVALID && AWREADY && WVALID && WREADY) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end else if (AWVALID && AWREADY) begin
          wr_next = WR_HAVE_AW;
        end else if (WVALID && WREADY) begin
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        WREADY = ARESETn;
        if (WVALID && WREADY) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end
      end
      WR_HAVE_W: begin
        AWREADY = ARESETn;
        if (AWVALID && AWREADY) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Operands come from the live channel unless that half was captured earlier.
  always_comb begin
    wr_idx  = (wr_state == WR_HAVE_AW) ? aw_idx_q : AWADDR[ADDR_WIDTH-1:OFFS];
    wr_data = (wr_state == WR_HAVE_W)  ? w_data_q : WDATA;
    wr_strb = (wr_state == WR_HAVE_W)  ? w_strb_q : WSTRB;
  end

  // Any index that matches no register falls through to DECERR.
  always_comb begin
    wr_resp = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
`ifdef AXIL_RO_REGS_EN
        wr_resp = (i >= RO_BASE) ? RESP_SLVERR : RESP_OKAY;
`else
        wr_resp = RESP_OKAY;
`endif
      end
    end
  end

  always_ff @(posedge ACLKn) begin
    if (!ARESETn) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      BRESP    <= RESP_OKAY;
    end else begin
      if (AWVALID && AWREADY) aw_idx_q <= AWADDR[ADDR_WIDTH-1:OFFS];
      if (WVALID && WREADY) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_commit) BRESP <= wr_resp;
    end
  end

  // NOTE: the register array is reset element by element because every
  // register must read 0 after reset; it is a flop array, not a RAM macro.
  always_ff @(posedge ACLKn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && (wr_resp == RESP_OKAY)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < STRB_W; k++) begin
          if ((wr_idx == IDX_W'(i)) && wr_strb[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        ARREADY = ARESETn;
        if (ARVALID && ARREADY) rd_next = RD_RESP;
      end
      RD_RESP: begin
        RVALID = 1'b1;
        if (RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ar_idx = ARADDR[ADDR_WIDTH-1:OFFS];
  assign ar_hs  = ARVALID && ARREADY;

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_val  = cur_val[i];
        rd_resp = RESP_OKAY;
      end
    end
  end

  // NOTE: non-blocking updates mean a read sampled on the same edge as a
  // write commit sees the pre-write register value.
  always_ff @(posedge ACLKn) begin
    if (!ARESETn) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      RDATA <= rd_val;
      RRESP <= rd_resp;
    end
  end

endmodule
